// File: rtl/param_regfile.sv
// Parameterised 2-read/1-write register file with a clear-sweep FSM that zeroes one register per cycle.
// Optional macro REGFILE_BYPASS_EN forwards an accepted write straight to a matching read port.
module param_regfile #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    aaddr,
  input  logic [AW-1:0]    baddr,
  output logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] bout,
  input  logic [AW-1:0]    oaddr,
  input  logic [WIDTH-1:0] oin,
  input  logic             we,
  input  logic             clr,
  output logic             busy
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0] mem_reg  [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];
  logic            sweep;
  logic            wr_acc;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; clr during CLEAR is deliberately ignored
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = 1'b0;
    sweep = 1'b0;
    if (state_reg == CLEAR) begin
      busy  = 1'b1;
      sweep = 1'b1;
    end
  end

  assign wr_acc = we && !busy;

  // Per-register update: sweep and write never coincide because writes need busy=0
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      always_comb begin
        mem_next[gi] = mem_reg[gi];
        if (sweep && (cnt_reg == AW'(gi)))
          mem_next[gi] = '0;
        else if (wr_acc && (oaddr == AW'(gi)))
          mem_next[gi] = oin;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign aout = (wr_acc && (oaddr == aaddr)) ? oin : mem_reg[aaddr];
  assign bout = (wr_acc && (oaddr == baddr)) ? oin : mem_reg[baddr];
`else
  assign aout = mem_reg[aaddr];
  assign bout = mem_reg[baddr];
`endif

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 The block SHALL have parameter AW, default 2, address bits; depth DEPTH = 2**AW registers.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port aaddr  input  AW  read port A address.
REQ-006 The block SHALL have port baddr  input  AW  read port B address.
REQ-007 The block SHALL have port aout  output  WIDTH  read port A data, combinational.
REQ-008 The block SHALL have port bout  output  WIDTH  read port B data, combinational.
REQ-009 The block SHALL have port oaddr  input  AW  write address.
REQ-010 The block SHALL have port oin  input  WIDTH  write data.
REQ-011 The block SHALL have port we  input  1  write enable.
REQ-012 The block SHALL have port clr  input  1  clear-sweep request, sampled on clk edge.
REQ-013 The block SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 Reads SHALL be asynchronous: aout = reg[aaddr], bout = reg[baddr], with zero-cycle latency.
REQ-015 A write SHALL be accepted when we=1 and busy=0; reg[oaddr] takes oin at that edge, so it is visible on reads the next cycle.
REQ-016 When busy=1, writes SHALL be dropped with no register change.
REQ-017 The FSM SHALL have states IDLE and CLEAR, plus an AW-bit sweep counter cnt.
REQ-018 In IDLE with clr=1 at an edge, the FSM SHALL go to CLEAR, set cnt=0 and assert busy from the next cycle.
REQ-019 In CLEAR, each edge SHALL write 0 to reg[cnt] and increment cnt.
REQ-020 The edge that clears reg[DEPTH-1] SHALL return the FSM to IDLE with cnt wrapping to 0, so busy is high for exactly DEPTH cycles.
REQ-021 clr asserted while busy=1 SHALL be ignored: no restart and no extension of the sweep.
REQ-022 If clr=1 and an accepted write occur in the same IDLE edge, the write SHALL take effect, and the subsequent sweep SHALL zero that register as well.
REQ-023 Reads during CLEAR SHALL return the current contents: swept registers read 0, unswept registers keep their old values.
REQ-024 Two read ports addressing the same register SHALL return identical data.

Reset
REQ-025 On an edge with rst=0, all DEPTH registers SHALL be set to 0, the state to IDLE, cnt to 0 and busy to 0.
REQ-026 rst=0 SHALL take priority over we and clr, and SHALL abort a sweep in progress.
REQ-027 Outputs after reset SHALL be aout=0, bout=0 and busy=0.

Configuration
REQ-028 The macro SHALL be named REGFILE_BYPASS_EN.
REQ-029 With REGFILE_BYPASS_EN defined, when a write is accepted and oaddr equals aaddr (or baddr), that port SHALL output oin combinationally in the same cycle.
REQ-030 Without REGFILE_BYPASS_EN, read ports SHALL output stored contents only, with the new value visible the cycle after the write.
REQ-031 With REGFILE_BYPASS_EN defined, bypass SHALL never apply while busy=1, because those writes are dropped.

Verification
REQ-032 Reset: WIDTH=16, AW=2; write 0x1234 to r1, apply rst=0 for one edge, read aaddr=1 -> aout=0x0000 and busy=0.
REQ-033 Write/read: write 0xBEEF to r2 and 0x0F0F to r3, then aaddr=2 and baddr=3 -> aout=0xBEEF, bout=0x0F0F on the next cycle.
REQ-034 Clear sweep: fill r0..r3 with 0xAAAA and pulse clr -> busy high for exactly 4 cycles; r0 reads 0 after the 1st busy edge while r3 still reads 0xAAAA; all registers read 0 when busy falls.
REQ-035 Write during busy: issue we=1, oaddr=1, oin=0x5555 in the 2nd busy cycle -> r1 reads 0 after the sweep; a clr pulse during busy does not extend busy beyond 4 cycles.
REQ-036 Bypass: with REGFILE_BYPASS_EN, we=1, oaddr=aaddr=2, oin=0x7777 with r2=0 -> aout=0x7777 in the same cycle; without the macro, aout=0 that cycle and 0x7777 the next.
REQ-037 Reset mid-sweep: apply rst=0 in the 2nd busy cycle -> busy=0 next cycle, all registers 0, and a write of 0x1111 on the following cycle is accepted.
